issue_stage: RTL

- Sits directly downstream of the decode queue and consumes its head micro-op.
- Detects register hazards with a per-register pending scoreboard.
- Reads operands from the register file, with a writeback bypass, and latches the issued op into a single issue register that feeds the execute stage over a valid/ready handshake.
- Back-pressures the decode queue through `stall`.

---
 rtl/issue_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/issue_stage.sv
// Issue stage: takes the decode-queue head, blocks it on register hazards
// using a per-register pending scoreboard, picks operands from the register file
// or the writeback bypass, and holds the issued op in a single issue register
// that is handed to execute over a valid/ready handshake.
module issue_stage #(
  parameter int                    MICRO_W    = 8,
  parameter logic [MICRO_W-1:0]    MICRO_NOP  = {MICRO_W{1'b0}},
  parameter int                    REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] REG_NONE   = {REG_ADDR_W{1'b1}},
  parameter int                    IMM_W      = 64,
  parameter int                    BIT_MODE_W = 2,
  parameter int                    ADDR_W     = 64,
  parameter int                    DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MICRO_W-1:0]    deq_opcode_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_s_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_t_head,
  input  logic [IMM_W-1:0]      deq_immediate_head,
  input  logic [BIT_MODE_W-1:0] deq_bit_mode_head,
  input  logic                  deq_efl_mode_head,
  input  logic [ADDR_W-1:0]     deq_pc_head,
  output logic                  stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_addr_s,
  output logic [REG_ADDR_W-1:0] rf_addr_t,
  input  logic [DATA_W-1:0]     rf_data_s,
  input  logic [DATA_W-1:0]     rf_data_t,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  iss_valid,
  input  logic                  exe_ready,
  output logic [MICRO_W-1:0]    iss_opcode,
  output logic [REG_ADDR_W-1:0] iss_reg_addr_d,
  output logic [IMM_W-1:0]      iss_immediate,
  output logic [BIT_MODE_W-1:0] iss_bit_mode,
  output logic                  iss_efl_mode,
  output logic [ADDR_W-1:0]     iss_pc,
  output logic [DATA_W-1:0]     iss_src_s,
  output logic [DATA_W-1:0]     iss_src_t
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic                head_valid_s;
  logic                byp_s_s, byp_t_s, byp_d_s;
  logic                hazard_s;
  logic                out_busy_s;
  logic                fire_s;
  logic [DATA_W-1:0]   src_s_s, src_t_s;

  // A writeback to register x this cycle resolves a pending write on x.
  function automatic logic bypass_hit(input logic                  en,
                                      input logic [REG_ADDR_W-1:0] wa,
                                      input logic [REG_ADDR_W-1:0] x);
    return en & (wa == x) & (x != REG_NONE);
  endfunction

  // Register x blocks issue when it has an outstanding write not resolved now.
  function automatic logic hazard_on(input logic [NUM_REGS-1:0]   pend,
                                     input logic                  hit,
                                     input logic [REG_ADDR_W-1:0] x);
    return (x != REG_NONE) & pend[x] & ~hit;
  endfunction

  assign rf_addr_s = deq_reg_addr_s_head;
  assign rf_addr_t = deq_reg_addr_t_head;

  // Hazard detection, handshake decisions, operand bypass and next scoreboard.
  always_comb begin
    head_valid_s = (deq_opcode_head != MICRO_NOP);
    byp_s_s      = bypass_hit(wb_en, wb_addr, deq_reg_addr_s_head);
    byp_t_s      = bypass_hit(wb_en, wb_addr, deq_reg_addr_t_head);
    byp_d_s      = bypass_hit(wb_en, wb_addr, deq_reg_addr_d_head);
    hazard_s     = head_valid_s &
                   (hazard_on(pend_r, byp_s_s, deq_reg_addr_s_head) |
                    hazard_on(pend_r, byp_t_s, deq_reg_addr_t_head) |
                    hazard_on(pend_r, byp_d_s, deq_reg_addr_d_head));
    out_busy_s   = iss_valid & ~exe_ready;
    stall        = ~flush & head_valid_s & (hazard_s | out_busy_s);
    fire_s       = ~flush & head_valid_s & ~hazard_s & ~out_busy_s;
    src_s_s      = byp_s_s ? wb_data : rf_data_s;
    src_t_s      = byp_t_s ? wb_data : rf_data_t;
    // Clear first, then set, so a same-cycle set of the same register wins.
    clr_mask_s   = (wb_en && (wb_addr != REG_NONE)) ? (ONE_HOT0 << wb_addr)
                                                    : {NUM_REGS{1'b0}};
    set_mask_s   = (fire_s && (deq_reg_addr_d_head != REG_NONE))
                   ? (ONE_HOT0 << deq_reg_addr_d_head) : {NUM_REGS{1'b0}};
    pend_nxt_s   = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Issue register and scoreboard update; flush empties both without writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid      <= 1'b0;
      pend_r         <= {NUM_REGS{1'b0}};
      iss_opcode     <= {MICRO_W{1'b0}};
      iss_reg_addr_d <= {REG_ADDR_W{1'b0}};
      iss_immediate  <= {IMM_W{1'b0}};
      iss_bit_mode   <= {BIT_MODE_W{1'b0}};
      iss_efl_mode   <= 1'b0;
      iss_pc         <= {ADDR_W{1'b0}};
      iss_src_s      <= {DATA_W{1'b0}};
      iss_src_t      <= {DATA_W{1'b0}};
    end else if (flush) begin
      iss_valid <= 1'b0;
      pend_r    <= {NUM_REGS{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      if (fire_s) begin
        iss_valid      <= 1'b1;
        iss_opcode     <= deq_opcode_head;
        iss_reg_addr_d <= deq_reg_addr_d_head;
        iss_immediate  <= deq_immediate_head;
        iss_bit_mode   <= deq_bit_mode_head;
        iss_efl_mode   <= deq_efl_mode_head;
        iss_pc         <= deq_pc_head;
        iss_src_s      <= src_s_s;
        iss_src_t      <= src_t_s;
      end else if (exe_ready) begin
        iss_valid <= 1'b0;
      end else begin
        iss_valid <= iss_valid;
      end
    end
  end

endmodule
